// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi
// Description : Multi-channel PWM generator. A shared prescaler and period
//               counter drive CHANNELS comparators. Duty values and the
//               alignment mode are double-buffered (shadow/active) and are
//               applied only at period boundaries. Edge-aligned and
//               center-aligned counting are supported.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi #(
  parameter int BITS        = 4,   // counter resolution, M = 2^BITS - 1
  parameter int CHANNELS    = 4,   // number of PWM outputs
  parameter int TIMER_DELAY = 10   // clocks per counter tick
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           mode_in,
  input  logic                           duty_we,
  input  logic [CHANNELS*(BITS+1)-1:0]   duty_in,
  output logic [CHANNELS-1:0]            pwm_out,
  output logic                           period_start,
  output logic                           upd_pending
);

  // Duty is one bit wider than the counter so that 100% is representable.
  localparam int DW = BITS + 1;
  localparam int PW = (TIMER_DELAY > 1) ? $clog2(TIMER_DELAY) : 1;

  localparam logic [BITS-1:0] c_CNT_MAX    = '1;
  localparam logic [PW-1:0]   c_PRESC_LAST = PW'(TIMER_DELAY - 1);

  // Counting direction; only meaningful in center-aligned mode.
  localparam logic [0:0] c_DIR_UP   = 1'b0;
  localparam logic [0:0] c_DIR_DOWN = 1'b1;

  logic [PW-1:0]            r_presc;
  logic [BITS-1:0]          r_cnt;
  logic [0:0]               r_dir;
  logic [CHANNELS*DW-1:0]   r_shadow_duty;
  logic                     r_shadow_mode;
  logic [CHANNELS*DW-1:0]   r_active_duty;
  logic                     r_active_mode;

  logic                     w_tick;
  logic                     w_boundary;
  logic [CHANNELS-1:0]      w_hit;

  // One counter step every TIMER_DELAY clocks.
  assign w_tick = (r_presc == c_PRESC_LAST);

  // Period end: top of the ramp in edge mode, return to zero in center mode.
  assign w_boundary = en && w_tick &&
                      (r_active_mode ? ((r_dir == c_DIR_DOWN) && (r_cnt == '0))
                                     : (r_cnt == c_CNT_MAX));

  // Per-channel comparators; duties >= 2^BITS are always above the counter.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    assign w_hit[gi] = ({1'b0, r_cnt} < r_active_duty[gi*DW +: DW]);
  end

  // Prescaler: free-runs while enabled, parked at zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (!en || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Period counter and direction; every boundary restarts at zero counting up
  // so a mode change never lands mid-ramp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_dir <= c_DIR_UP;
    end else if (!en) begin
      r_cnt <= '0;
      r_dir <= c_DIR_UP;
    end else if (w_tick) begin
      if (w_boundary) begin
        r_cnt <= '0;
        r_dir <= c_DIR_UP;
      end else if (!r_active_mode) begin
        r_cnt <= r_cnt + BITS'(1);
      end else if (r_dir == c_DIR_UP) begin
        if (r_cnt == c_CNT_MAX) begin
          r_dir <= c_DIR_DOWN;
        end else begin
          r_cnt <= r_cnt + BITS'(1);
        end
      end else begin
        r_cnt <= r_cnt - BITS'(1);
      end
    end
  end

  // Shadow registers accept every write strobe, enabled or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow_duty <= '0;
      r_shadow_mode <= 1'b0;
    end else if (duty_we) begin
      r_shadow_duty <= duty_in;
      r_shadow_mode <= mode_in;
    end
  end

  // Active registers follow the shadow continuously while idle, else only at
  // a boundary (a coincident write is therefore deferred one period).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active_duty <= '0;
      r_active_mode <= 1'b0;
    end else if (!en || w_boundary) begin
      r_active_duty <= r_shadow_duty;
      r_active_mode <= r_shadow_mode;
    end
  end

  // Registered outputs: PWM compare, boundary pulse and pending-update flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
      upd_pending  <= 1'b0;
    end else if (!en) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
      upd_pending  <= 1'b0;
    end else begin
      pwm_out      <= w_hit;
      period_start <= w_boundary;
      if (w_boundary) begin
        upd_pending <= duty_we;
      end else if (duty_we) begin
        upd_pending <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_multi
// Description : Self-checking bench for pwm_multi. A period-position model
//               predicts every registered output each clock; directed
//               scenarios add literal expectations on periods and high times.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multi;

  localparam int BITS = 4;
  localparam int CH   = 4;
  localparam int TD   = 10;
  localparam int DW   = BITS + 1;
  localparam int NV   = 2 ** BITS;

  logic              clk;
  logic              rst;
  logic              en;
  logic              mode_in;
  logic              duty_we;
  logic [CH*DW-1:0]  duty_in;
  logic [CH-1:0]     pwm_out;
  logic              period_start;
  logic              upd_pending;

  int n_checks = 0;
  int n_pass   = 0;

  pwm_multi #(.BITS(BITS), .CHANNELS(CH), .TIMER_DELAY(TD)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode_in      (mode_in),
    .duty_we      (duty_we),
    .duty_in      (duty_in),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .upd_pending  (upd_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  // State is the clock position inside the current period; the counter value
  // is derived arithmetically from that position.
  int           m_pos;
  bit           m_mode_sh, m_mode_act;
  int           m_sh  [CH];
  int           m_act [CH];
  logic [CH-1:0] m_pwm;
  logic         m_ps, m_up;

  function automatic int model_cnt();
    int t;
    t = m_pos / TD;
    if (m_mode_act && t >= NV) return 2 * NV - 1 - t;
    return t;
  endfunction

  function automatic bit model_bnd();
    return en && (m_pos == TD * (m_mode_act ? 2 * NV : NV) - 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos      <= 0;
      m_mode_sh  <= 1'b0;
      m_mode_act <= 1'b0;
      m_pwm      <= '0;
      m_ps       <= 1'b0;
      m_up       <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        m_sh[i]  <= 0;
        m_act[i] <= 0;
      end
    end else begin
      for (int i = 0; i < CH; i++) m_pwm[i] <= en && (model_cnt() < m_act[i]);
      m_ps <= model_bnd();
      if (!en) m_up <= 1'b0;
      else if (model_bnd()) m_up <= duty_we;
      else if (duty_we) m_up <= 1'b1;
      if (!en || model_bnd()) begin
        m_pos      <= 0;
        m_mode_act <= m_mode_sh;
        for (int i = 0; i < CH; i++) m_act[i] <= m_sh[i];
      end else begin
        m_pos <= m_pos + 1;
      end
      if (duty_we) begin
        m_mode_sh <= mode_in;
        for (int i = 0; i < CH; i++) m_sh[i] <= int'(duty_in[i*DW +: DW]);
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the clock edge.
  always @(posedge clk) begin
    #1;
    chk("pwm_out",      32'(pwm_out),      32'(m_pwm));
    chk("period_start", 32'(period_start), 32'(m_ps));
    chk("upd_pending",  32'(upd_pending),  32'(m_up));
  end

  // ---------------- stimulus helpers ----------------
  int m_wait;
  int m_len;
  int m_hi       [CH];
  int m_hi_first [CH];

  function automatic logic [CH*DW-1:0] pack(input int d0, input int d1, input int d2, input int d3);
    return {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
  endfunction

  task automatic write_duty(input logic [CH*DW-1:0] d, input logic m);
    @(negedge clk);
    duty_in = d;
    mode_in = m;
    duty_we = 1'b1;
    @(negedge clk);
    duty_we = 1'b0;
  endtask

  // Samples until the next period_start pulse; m_wait counts samples taken.
  task automatic wait_ps();
    bit ok;
    ok = 1'b0;
    m_wait = 0;
    while (!ok && m_wait < 1000) begin
      @(posedge clk); #1;
      m_wait++;
      ok = period_start;
    end
    if (!ok) chk("wait_ps_timeout", 32'(0), 32'(1));
  endtask

  // Counts high samples per channel over one full period, starting right
  // after a period_start sample and ending on the next one.
  task automatic measure();
    bit done;
    done = 1'b0;
    m_len = 0;
    for (int i = 0; i < CH; i++) begin
      m_hi[i] = 0;
      m_hi_first[i] = 0;
    end
    while (!done && m_len < 1000) begin
      @(posedge clk); #1;
      m_len++;
      for (int i = 0; i < CH; i++) begin
        if (pwm_out[i]) begin
          m_hi[i]++;
          if (m_len <= TD * NV) m_hi_first[i]++;
        end
      end
      done = period_start;
    end
    if (!done) chk("measure_timeout", 32'(0), 32'(1));
  endtask

  task automatic count_idle(input string nm, input int n);
    int s;
    s = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      s += int'(pwm_out != '0);
    end
    chk(nm, 32'(s), 32'(0));
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst     = 1'b1;
    en      = 1'b1;
    mode_in = 1'b0;
    duty_we = 1'b1;
    duty_in = pack(5, 5, 5, 5);

    // Reset holds everything low even with enable and writes active.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pwm",   32'(pwm_out),      32'(0));
    chk("rst_ps",    32'(period_start), 32'(0));
    chk("rst_upd",   32'(upd_pending),  32'(0));
    @(negedge clk) duty_we = 1'b0;
    @(negedge clk) rst = 1'b0;
    count_idle("rst_release_idle", 200);

    // Edge mode, duties {0,4,8,16} loaded while disabled.
    @(negedge clk) en = 1'b0;
    write_duty(pack(0, 4, 8, 16), 1'b0);
    @(negedge clk) en = 1'b1;
    wait_ps();
    chk("first_period_len", 32'(m_wait), 32'(160));
    measure();
    chk("edge_len", 32'(m_len),   32'(160));
    chk("edge_hi0", 32'(m_hi[0]), 32'(0));
    chk("edge_hi1", 32'(m_hi[1]), 32'(40));
    chk("edge_hi2", 32'(m_hi[2]), 32'(80));
    chk("edge_hi3", 32'(m_hi[3]), 32'(160));

    // Clamp: duty 31 is constant high, duty 0 constant low.
    write_duty(pack(31, 4, 8, 16), 1'b0);
    wait_ps();
    for (int k = 0; k < 3; k++) begin
      measure();
      chk("clamp_hi0", 32'(m_hi[0]), 32'(160));
    end
    write_duty(pack(0, 4, 8, 16), 1'b0);
    wait_ps();
    measure();
    chk("zero_hi0", 32'(m_hi[0]), 32'(0));

    // Shadow update mid-period.
    write_duty(pack(8, 4, 8, 16), 1'b0);
    wait_ps();
    fork
      measure();
      begin
        repeat (49) @(negedge clk);
        write_duty(pack(12, 4, 8, 16), 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("upd_pending_mid", 32'(upd_pending), 32'(1));
      end
    join
    chk("shadow_cur_hi0", 32'(m_hi[0]),      32'(80));
    chk("shadow_ps",      32'(period_start), 32'(1));
    chk("shadow_upd_clr", 32'(upd_pending),  32'(0));

    // Write coincident with the boundary tick: deferred one more period.
    fork
      measure();
      begin
        repeat (159) @(negedge clk);
        write_duty(pack(4, 4, 8, 16), 1'b0);
      end
    join
    chk("coin_prev_hi0", 32'(m_hi[0]),     32'(120));
    chk("coin_upd",      32'(upd_pending), 32'(1));
    measure();
    chk("coin_next_hi0", 32'(m_hi[0]),     32'(120));
    chk("coin_upd_clr",  32'(upd_pending), 32'(0));
    measure();
    chk("coin_late_hi0", 32'(m_hi[0]),     32'(40));

    // Center-aligned mode.
    write_duty(pack(8, 4, 8, 16), 1'b1);
    wait_ps();
    measure();
    chk("ctr_len",      32'(m_len),                    32'(320));
    chk("ctr_hi0",      32'(m_hi[0]),                  32'(160));
    chk("ctr_hi0_pre",  32'(m_hi_first[0]),            32'(80));
    chk("ctr_hi0_post", 32'(m_hi[0] - m_hi_first[0]),  32'(80));
    chk("ctr_hi1",      32'(m_hi[1]),                  32'(80));
    chk("ctr_hi3",      32'(m_hi[3]),                  32'(320));

    // Back to edge mode.
    write_duty(pack(8, 4, 8, 16), 1'b0);
    wait_ps();
    measure();
    chk("back_edge_len", 32'(m_len),   32'(160));
    chk("back_edge_hi0", 32'(m_hi[0]), 32'(80));

    // Abort by dropping enable mid-high, then restart.
    repeat (30) @(posedge clk);
    #1;
    chk("abort_pre_hi", 32'(pwm_out[0]), 32'(1));
    @(negedge clk) en = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_pwm", 32'(pwm_out), 32'(0));
    repeat (5) @(negedge clk);
    en = 1'b1;
    wait_ps();
    chk("reenable_len", 32'(m_wait), 32'(160));
    measure();
    chk("reenable_hi0", 32'(m_hi[0]), 32'(80));

    // Asynchronous reset between clock edges.
    repeat (20) @(posedge clk);
    #2;
    chk("async_pre", 32'(pwm_out), 32'(4'hF));
    rst = 1'b1;
    #1;
    chk("async_pwm", 32'(pwm_out),     32'(0));
    chk("async_upd", 32'(upd_pending), 32'(0));
    @(negedge clk) rst = 1'b0;
    count_idle("async_release_idle", 200);
    @(negedge clk) en = 1'b0;
    write_duty(pack(2, 4, 8, 16), 1'b0);
    @(negedge clk) en = 1'b1;
    wait_ps();
    chk("post_rst_len", 32'(m_wait), 32'(160));
    measure();
    chk("post_rst_hi0", 32'(m_hi[0]), 32'(20));

    repeat (2) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
